// File: rtl/datapath_pkg.sv
// Shared result encodings and FSM states for the datapath arbiter slice.
package datapath_pkg;

    localparam logic [2:0] RES_LT = 3'b001;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_GT = 3'b100;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

endpackage

// File: rtl/datapath_arbiter_if.sv
// Request/response channels of both requesters plus arbiter status.
interface datapath_arbiter_if #(parameter int W = 12);

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [W-1:0] req0_c;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic [W-1:0] req1_c;

    logic         rsp0_valid;
    logic         rsp0_ready;
    logic [2:0]   rsp0_result;

    logic         rsp1_valid;
    logic         rsp1_ready;
    logic [2:0]   rsp1_result;

    logic         busy;
    logic [7:0]   op_count;

    // master is the requester side, slave is the arbiter
    modport master (
        output req0_valid, req0_a, req0_b, req0_c,
        output req1_valid, req1_a, req1_b, req1_c,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
        input  busy, op_count
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_c,
        input  req1_valid, req1_a, req1_b, req1_c,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
        output busy, op_count
    );

endinterface

// File: rtl/datapath_arbiter_datapath.sv
// Shared sum-and-compare block: (a + b) mod 2^W compared unsigned against c.
module sum #(parameter int W = 12) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);
    assign o_sum = i_a + i_b;
endmodule

module CMP import datapath_pkg::*; #(parameter int W = 12) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    output logic [2:0]   o_result
);
    always_comb begin
        if (i_x < i_y)
            o_result = RES_LT;
        else if (i_x == i_y)
            o_result = RES_EQ;
        else
            o_result = RES_GT;
    end
endmodule

module datapath #(parameter int W = 12) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [2:0]   o_result
);
    logic [W-1:0] w_sum;

    sum #(.W(W)) u_sum (
        .i_a   (i_a),
        .i_b   (i_b),
        .o_sum (w_sum)
    );

    CMP #(.W(W)) u_cmp (
        .i_x      (w_sum),
        .i_y      (i_c),
        .o_result (o_result)
    );
endmodule

// File: rtl/datapath_arbiter.sv
// Round-robin sharing of one datapath instance between two requesters.
module datapath_arbiter import datapath_pkg::*; #(parameter int W = 12) (
    input logic              clk,
    input logic              rst,
    datapath_arbiter_if.slave bus
);

    state_t       r_state;
    logic         r_last_grant;
    logic         r_grant;
    logic         r_busy;
    logic         r_rsp0_valid;
    logic         r_rsp1_valid;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_c;
    logic [2:0]   r_rsp_result;
    logic [7:0]   r_op_count;

    logic         w_any_valid;
    logic         w_grant;
    logic         w_rsp_ready;
    logic [2:0]   w_dp_result;

    // On a tie the requester that was not served last wins
    assign w_any_valid = bus.req0_valid | bus.req1_valid;
    assign w_grant     = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
    assign w_rsp_ready = r_grant ? bus.rsp1_ready : bus.rsp0_ready;

    assign bus.req0_ready  = (r_state == IDLE) && bus.req0_valid && !w_grant;
    assign bus.req1_ready  = (r_state == IDLE) && bus.req1_valid &&  w_grant;
    assign bus.rsp0_valid  = r_rsp0_valid;
    assign bus.rsp1_valid  = r_rsp1_valid;
    assign bus.rsp0_result = r_rsp_result & {3{r_rsp0_valid}};
    assign bus.rsp1_result = r_rsp_result & {3{r_rsp1_valid}};
    assign bus.busy        = r_busy;
    assign bus.op_count    = r_op_count;

    datapath #(.W(W)) u_datapath (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_c      (r_c),
        .o_result (w_dp_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_busy       <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_c          <= '0;
            r_rsp_result <= '0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_grant <= w_grant;
                        r_a     <= w_grant ? bus.req1_a : bus.req0_a;
                        r_b     <= w_grant ? bus.req1_b : bus.req0_b;
                        r_c     <= w_grant ? bus.req1_c : bus.req0_c;
                        r_busy  <= 1'b1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_result <= w_dp_result;
                    r_rsp0_valid <= !r_grant;
                    r_rsp1_valid <= r_grant;
                    r_state      <= RESP;
                end
                RESP: begin
                    // Result stays on the bus until the granted requester takes it
                    if (w_rsp_ready) begin
                        r_last_grant <= r_grant;
                        r_op_count   <= r_op_count + 8'd1;
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_arbiter.sv
// Directed plus randomized bench for datapath_arbiter against a transaction-level model.
module tb_datapath_arbiter;

    localparam int W = 12;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
    } op_t;

    typedef struct {
        int         id;
        logic [2:0] res;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    op_t  q0[$];
    op_t  q1[$];
    int   grantLog[$];
    rsp_t rspLog[$];

    int         mLast;
    int         mInflight;
    int         mAge;
    int         mCount;
    logic [2:0] mRes;

    datapath_arbiter_if #(.W(W)) bus ();

    datapath_arbiter #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s at %0t: observed %0h expected %0h", tag, $time, observed, expected);
        end
    endtask

    // Expected compare outcome from plain integer arithmetic
    function automatic logic [2:0] modelResult(input op_t op);
        int s;
        s = (int'(op.a) + int'(op.b)) % (1 << W);
        if (s < int'(op.c))  return 3'b001;
        if (s == int'(op.c)) return 3'b010;
        return 3'b100;
    endfunction

    function automatic op_t mkOp(input int a, input int b, input int c);
        op_t op;
        op.a = a[W-1:0];
        op.b = b[W-1:0];
        op.c = c[W-1:0];
        return op;
    endfunction

    function automatic op_t randOp();
        op_t op;
        op.a = W'($urandom_range(0, (1 << W) - 1));
        op.b = W'($urandom_range(0, (1 << W) - 1));
        if ($urandom_range(0, 2) == 0)
            op.c = op.a + op.b;
        else
            op.c = W'($urandom_range(0, (1 << W) - 1));
        return op;
    endfunction

    task automatic applyStimulus(input logic rr0, input logic rr1);
        bus.req0_valid = (q0.size() > 0);
        bus.req0_a     = (q0.size() > 0) ? q0[0].a : '0;
        bus.req0_b     = (q0.size() > 0) ? q0[0].b : '0;
        bus.req0_c     = (q0.size() > 0) ? q0[0].c : '0;
        bus.req1_valid = (q1.size() > 0);
        bus.req1_a     = (q1.size() > 0) ? q1[0].a : '0;
        bus.req1_b     = (q1.size() > 0) ? q1[0].b : '0;
        bus.req1_c     = (q1.size() > 0) ? q1[0].c : '0;
        bus.rsp0_ready = rr0;
        bus.rsp1_ready = rr1;
    endtask

    // One clock: drive, check at the falling edge, advance the model
    task automatic step(input logic rr0, input logic rr1);
        int   g;
        logic respond;
        logic [2:0] obsRes;
        rsp_t r;
        applyStimulus(rr0, rr1);
        @(negedge clk);
        g = -1;
        if (mInflight < 0) begin
            if (q0.size() > 0 && q1.size() > 0) g = (mLast == 0) ? 1 : 0;
            else if (q0.size() > 0)             g = 0;
            else if (q1.size() > 0)             g = 1;
        end
        respond = (mInflight >= 0) && (mAge >= 2);
        checkOutput("req0_ready", bus.req0_ready, g == 0);
        checkOutput("req1_ready", bus.req1_ready, g == 1);
        checkOutput("rsp0_valid", bus.rsp0_valid, respond && mInflight == 0);
        checkOutput("rsp1_valid", bus.rsp1_valid, respond && mInflight == 1);
        checkOutput("busy", bus.busy, mInflight >= 0);
        checkOutput("op_count", bus.op_count, mCount & 255);
        if (respond) begin
            obsRes = (mInflight == 0) ? bus.rsp0_result : bus.rsp1_result;
            checkOutput("rsp_result", obsRes, mRes);
            checkOutput("rsp_other_zero", (mInflight == 0) ? bus.rsp1_result : bus.rsp0_result, 0);
        end
        if (g >= 0) begin
            mRes = (g == 0) ? modelResult(q0.pop_front()) : modelResult(q1.pop_front());
            mInflight = g;
            mAge = 1;
            grantLog.push_back(g);
        end else if (respond && ((mInflight == 0) ? rr0 : rr1)) begin
            r.id  = mInflight;
            r.res = (mInflight == 0) ? bus.rsp0_result : bus.rsp1_result;
            rspLog.push_back(r);
            mCount++;
            mLast = mInflight;
            mInflight = -1;
        end else if (mInflight >= 0) begin
            mAge++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int maxCycles);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || mInflight >= 0) && n < maxCycles) begin
            step(1'b1, 1'b1);
            n++;
        end
        checkOutput("drain_done", (q0.size() == 0 && q1.size() == 0 && mInflight < 0), 1);
    endtask

    task automatic doReset(input int cycles);
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete();
        q1.delete();
        mLast = 1;
        mInflight = -1;
        mAge = 0;
        mCount = 0;
    endtask

    initial begin
        logic [2:0] held;
        applyStimulus(1'b1, 1'b1);
        doReset(2);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_op_count", bus.op_count, 0);
        checkOutput("reset_rsp0_valid", bus.rsp0_valid, 0);
        checkOutput("reset_rsp1_valid", bus.rsp1_valid, 0);

        // Single less-than request
        q0.push_back(mkOp(5, 7, 20));
        drain(20);
        checkOutput("t1_id", rspLog[rspLog.size()-1].id, 0);
        checkOutput("t1_result", rspLog[rspLog.size()-1].res, 3'b001);
        checkOutput("t1_op_count", bus.op_count, 1);

        // Wrap-around sums comparing equal
        q1.push_back(mkOp(12'hFFF, 2, 1));
        q1.push_back(mkOp(12'h800, 12'h800, 0));
        drain(20);
        checkOutput("t2_wrap_a", rspLog[rspLog.size()-2].res, 3'b010);
        checkOutput("t2_wrap_b", rspLog[rspLog.size()-1].res, 3'b010);
        checkOutput("t2_id", rspLog[rspLog.size()-1].id, 1);

        // Tie straight after reset
        doReset(2);
        rspLog.delete();
        q0.push_back(mkOp(10, 10, 5));
        q1.push_back(mkOp(1, 1, 2));
        drain(20);
        checkOutput("t3_count", rspLog.size(), 2);
        checkOutput("t3_first_id", rspLog[0].id, 0);
        checkOutput("t3_first_res", rspLog[0].res, 3'b100);
        checkOutput("t3_second_id", rspLog[1].id, 1);
        checkOutput("t3_second_res", rspLog[1].res, 3'b010);

        // Fairness with both requesters permanently busy
        doReset(2);
        grantLog.delete();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(randOp());
            q1.push_back(randOp());
        end
        drain(40);
        checkOutput("fair_len", grantLog.size(), 6);
        for (int i = 0; i < 6; i++)
            checkOutput("fair_grant", grantLog[i], i % 2);
        checkOutput("fair_op_count", bus.op_count, 6);

        // Response backpressure on requester 0
        q0.push_back(mkOp(100, 50, 150));
        for (int i = 0; i < 6 && !(mInflight == 0 && mAge >= 2); i++)
            step(1'b0, 1'b1);
        checkOutput("bp_rsp0_valid", bus.rsp0_valid, 1);
        held = bus.rsp0_result;
        q1.push_back(mkOp(3, 4, 9));
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1);
            checkOutput("bp_hold_result", bus.rsp0_result, held);
            checkOutput("bp_req1_ready_low", bus.req1_ready, 0);
        end
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        checkOutput("bp_req1_granted", grantLog[grantLog.size()-1], 1);
        drain(20);

        // Reset while the operation is executing
        q0.push_back(mkOp(7, 8, 1));
        step(1'b1, 1'b1);
        doReset(1);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_rsp0_valid", bus.rsp0_valid, 0);
        checkOutput("rst_rsp1_valid", bus.rsp1_valid, 0);
        checkOutput("rst_op_count", bus.op_count, 0);
        grantLog.delete();
        q0.push_back(randOp());
        q1.push_back(randOp());
        drain(20);
        checkOutput("rst_tie_first", grantLog[0], 0);
        checkOutput("rst_tie_second", grantLog[1], 1);

        // Randomized traffic with random response backpressure
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0 && q0.size() < 3) q0.push_back(randOp());
            if ($urandom_range(0, 3) == 0 && q1.size() < 3) q1.push_back(randOp());
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        drain(200);
        checkOutput("rand_op_count", bus.op_count, mCount & 255);

        $display("[TB] stimulus complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
